// File: rtl/fanout_pkg.sv
// Shared definitions for the registered one-to-N broadcast stage.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
// Contents: MAX_LOADS bound, load_mask_t (widest branch mask), popcount().
package fanout_pkg;

    localparam int MAX_LOADS = 16;

    typedef logic [MAX_LOADS-1:0] load_mask_t;

    // Number of enabled branches in a mask, i.e. how many deliveries one word owes.
    function automatic logic [4:0] popcount(input load_mask_t m);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_LOADS; i++) begin
            n = n + {4'b0000, m[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fanout_fork_stage_if.sv
// Handshake bundle between one driver stream and the N-branch broadcast stage.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry flow control in each direction.
// Signals: in_valid/in_ready/in_data/load_mask (driver side),
//          out_valid/out_ready/out_data (branch side), busy (status).
// Modports: master = driver + load bank (bench side), slave = the stage.
interface fanout_fork_stage_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_LOADS = 3
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    logic [NUM_LOADS-1:0] load_mask;
    logic [NUM_LOADS-1:0] out_valid;
    logic [NUM_LOADS-1:0] out_ready;
    logic [DATA_W-1:0]    out_data;
    logic                 busy;

    modport master (
        output in_valid, in_data, load_mask, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, load_mask, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fanout_branch_ctl.sv
// Per-branch pending flag: set from the mask on accept, cleared when the branch takes the word.
// Latency: pending bit visible the cycle after accept.
// Backpressure: holds the pending bit until ready_i is seen while pending.
// Ports: clk, rst_n, accept_i, mask_i, done_now_i, ready_i -> pend_o
//        (+ cnt_o per-branch completion count when FANOUT_STATS_EN is defined).
module fanout_branch_ctl
    import fanout_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept_i,
    input  logic             mask_i,
    input  logic             done_now_i,
    input  logic             ready_i,
`ifdef FANOUT_STATS_EN
    output logic [CNT_W-1:0] cnt_o,
`endif
    output logic             pend_o
);
    logic pend_q, pend_d;
    logic take;

    // A ready on an idle branch is not a transfer.
    assign take = pend_q & ready_i;

    always_comb begin
        pend_d = pend_q;
        if (accept_i) begin
            // A new word overrides any completion landing in the same cycle.
            pend_d = mask_i;
        end else if (done_now_i) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q & ~take;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

`ifdef FANOUT_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (take) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/fanout_fork_stage.sv
// Registered one-to-N broadcast: captures one word and offers it to every enabled branch.
// Latency: 1 cycle accept-to-out_valid; 1 word/cycle when all enabled branches are ready.
// Backpressure: in_ready only when every outstanding branch completes this cycle (or none owed).
// Ports: clk, rst_n (async active-low), bus (fanout_fork_stage_if.slave),
//        xfer_cnt[NUM_LOADS*CNT_W] per-branch transfer counts, present only
//        when the FANOUT_STATS_EN macro is defined.
module fanout_fork_stage
    import fanout_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_LOADS = 3,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fanout_fork_stage_if.slave         bus
`ifdef FANOUT_STATS_EN
    ,
    output logic [NUM_LOADS*CNT_W-1:0] xfer_cnt
`endif
);
    if (NUM_LOADS < 1 || NUM_LOADS > MAX_LOADS || CNT_W < 1 || DATA_W < 1) begin : g_bad_param
        $error("fanout_fork_stage: illegal parameter set");
    end

    logic [DATA_W-1:0]    data_q, data_d;
    logic [NUM_LOADS-1:0] pend;
    logic                 done_now;
    logic                 accept;

    // Every branch still owed the word is acknowledging now (trivially true when empty),
    // so the register can be refilled on this very edge without a bubble.
    assign done_now = ((pend & ~bus.out_ready) == '0);
    assign accept   = bus.in_valid & done_now;

    assign bus.in_ready  = done_now;
    assign bus.out_valid = pend;
    assign bus.out_data  = data_q;
    assign bus.busy      = |pend;

    // Payload only moves on accept, so it is stable while any branch is still pending.
    always_comb begin
        data_d = data_q;
        if (accept) begin
            data_d = bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    for (genvar i = 0; i < NUM_LOADS; i++) begin : g_branch
        fanout_branch_ctl #(
            .CNT_W (CNT_W)
        ) u_ctl (
            .clk        (clk),
            .rst_n      (rst_n),
            .accept_i   (accept),
            .mask_i     (bus.load_mask[i]),
            .done_now_i (done_now),
            .ready_i    (bus.out_ready[i]),
`ifdef FANOUT_STATS_EN
            .cnt_o      (xfer_cnt[i*CNT_W +: CNT_W]),
`endif
            .pend_o     (pend[i])
        );
    end

endmodule

// File: tb/tb_fanout_fork_stage.sv
module tb_fanout_fork_stage;
    import fanout_pkg::*;

    localparam int DW = 8;
    localparam int NL = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fanout_fork_stage_if #(.DATA_W(DW), .NUM_LOADS(NL)) bus ();

`ifdef FANOUT_STATS_EN
    logic [NL*16-1:0] xfer_cnt;
    fanout_fork_stage_if #(.DATA_W(DW), .NUM_LOADS(1)) bus2 ();
    logic [1:0] xfer_cnt2;

    fanout_fork_stage #(.DATA_W(DW), .NUM_LOADS(1), .CNT_W(2)) dut_wrap (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus2),
        .xfer_cnt (xfer_cnt2)
    );
`endif

    fanout_fork_stage #(.DATA_W(DW), .NUM_LOADS(NL), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef FANOUT_STATS_EN
        .xfer_cnt (xfer_cnt),
`endif
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;
    logic [DW-1:0] exp_q [NL][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard entry: the word is owed once to every branch enabled in the mask.
    task automatic expect_word(input logic [DW-1:0] d, input logic [NL-1:0] m);
        for (int i = 0; i < NL; i++) begin
            if (m[i]) exp_q[i].push_back(d);
        end
        pushed += int'(popcount(load_mask_t'(m)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until the edge that accepts it; waited = edges taken.
    task automatic send(input logic [DW-1:0] d, input logic [NL-1:0] m, output int waited);
        logic ok;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.load_mask = m;
        expect_word(d, m);
        waited = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
            waited++;
            if (!ok && waited > 50) begin
                chk("accept timeout", 32'(waited), 32'd0);
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: every branch transfer must match the oldest word owed to that branch,
    // and no branch may raise valid when nothing is owed to it.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NL; i++) begin
                if (bus.out_valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL branch%0d unexpected valid: got data %0h expected no valid", i, bus.out_data);
                    end else if (bus.out_ready[i]) begin
                        chk($sformatf("branch%0d data", i), 32'(bus.out_data), 32'(exp_q[i].pop_front()));
                        popped++;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.load_mask = '0;
        bus.out_ready = '0;
`ifdef FANOUT_STATS_EN
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.load_mask = '0;
        bus2.out_ready = '0;
`endif

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("in reset out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("idle out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle busy", 32'(bus.busy), 32'd0);
        chk("idle out_data", 32'(bus.out_data), 32'h00);
        step();

        // Full-rate broadcast: one accept per edge, no bubbles
        bus.out_ready = 3'b111;
        send(8'h11, 3'b111, w); chk("full-rate wait 11", 32'(w), 32'd1);
        send(8'h22, 3'b111, w); chk("full-rate wait 22", 32'(w), 32'd1);
        send(8'h33, 3'b111, w); chk("full-rate wait 33", 32'(w), 32'd1);
        chk("full-rate out_valid", 32'(bus.out_valid), 32'h7);
        chk("full-rate out_data", 32'(bus.out_data), 32'h33);
        bus.in_valid = 1'b0;
        step();

        // Staggered acks: b0 in cycle 1, b2 in cycle 3, b1 in cycle 5
        bus.out_ready = 3'b000;
        send(8'hA5, 3'b111, w);
        chk("stagger wait A5", 32'(w), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        expect_word(8'h5A, 3'b111);
        for (int c = 1; c <= 5; c++) begin
            bus.out_ready = {c >= 3, c >= 5, c >= 1};
            // Mask wiggles while busy must not disturb the held word.
            bus.load_mask = (c == 5) ? 3'b111 : 3'b001;
            @(negedge clk);
            chk($sformatf("stagger in_ready c%0d", c), 32'(bus.in_ready), 32'(c == 5));
            step();
        end
        chk("stagger next out_valid", 32'(bus.out_valid), 32'h7);
        chk("stagger next out_data", 32'(bus.out_data), 32'h5A);
        bus.in_valid  = 1'b0;
        bus.out_ready = 3'b111;
        step();

        // Masking: single branch, then zero mask
        send(8'hC3, 3'b010, w);
        chk("mask C3 out_valid", 32'(bus.out_valid), 32'h2);
        chk("mask C3 busy", 32'(bus.busy), 32'd1);
        send(8'h3C, 3'b000, w);
        chk("mask 3C out_valid", 32'(bus.out_valid), 32'h0);
        chk("mask 3C busy", 32'(bus.busy), 32'd0);
        bus.in_valid = 1'b0;
        step();
        chk("mask idle busy", 32'(bus.busy), 32'd0);

        // Async reset while a word is held for branch1
        bus.out_ready = 3'b000;
        send(8'h77, 3'b010, w);
        bus.in_valid = 1'b0;
        step();
        step();
        chk("held 77 out_valid", 32'(bus.out_valid), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(bus.out_valid), 32'h0);
        chk("arst in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst busy", 32'(bus.busy), 32'd0);
        chk("arst out_data", 32'(bus.out_data), 32'h00);
        // The held word is discarded, so nothing is owed any more.
        void'(exp_q[1].pop_front());
        pushed--;
        bus.out_ready = 3'b111;
        step();
        #3;
        rst_n = 1'b1;
        repeat (3) step();
        chk("post-reset out_valid", 32'(bus.out_valid), 32'h0);

`ifdef FANOUT_STATS_EN
        // Counters were cleared by the reset above.
        for (int k = 0; k < 5; k++) send(8'(8'h40 + k), 3'b101, w);
        for (int k = 0; k < 2; k++) send(8'(8'h50 + k), 3'b011, w);
        bus.in_valid = 1'b0;
        step();
        chk("xfer_cnt b0", 32'(xfer_cnt[15:0]), 32'd7);
        chk("xfer_cnt b1", 32'(xfer_cnt[31:16]), 32'd2);
        chk("xfer_cnt b2", 32'(xfer_cnt[47:32]), 32'd5);
        // Two-bit counter: five transfers wrap to one.
        bus2.out_ready = 1'b1;
        bus2.load_mask = 1'b1;
        bus2.in_valid  = 1'b1;
        repeat (5) step();
        bus2.in_valid = 1'b0;
        step();
        chk("xfer_cnt wrap", 32'(xfer_cnt2), 32'd1);
`endif

        repeat (3) step();
        chk("all words delivered", 32'(popped), 32'(pushed));
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("branch%0d queue empty", i), 32'(exp_q[i].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
